pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage 16-bit pipeline. Drives the stall/flush pins of the PC,
//  IF/ID, ID/EX and EX/MEM registers. Handles load-use hazards, taken branches/jumps, data-memory wait
//  states and a memory-timeout watchdog. Keeps saturating stall/flush performance counters.
// PARAMETERS
//  FLUSH_CYCLES  1     cycles flush is held after a taken branch (1..7); covers fetch latency
//  MEM_TIMEOUT   255   mem_busy cycles tolerated before mem_timeout is set (1..255)
//  CNT_W         16    width of the performance counters
// PORTS
//  clk           in   1      clock, rising edge
//  rst           in   1      asynchronous, active-low reset
//  id_rs1        in   3      ID-stage source register 1
//  id_rs2        in   3      ID-stage source register 2
//  id_use_rs1    in   1      ID instruction reads rs1
//  id_use_rs2    in   1      ID instruction reads rs2
//  ex_mem_read   in   1      EX-stage instruction is a load
//  ex_rd         in   3      EX-stage destination register
//  branch_taken  in   1      EX resolved a taken branch/jump (PC loads target this cycle)
//  mem_busy      in   1      data memory not ready; whole pipeline must hold
//  cnt_clr       in   1      synchronous clear of the performance counters
//  pc_stall      out  1      hold PC
//  if_id_stall   out  1      freeze IF/ID
//  if_id_flush   out  1      clear IF/ID to NOP
//  id_ex_stall   out  1      freeze ID/EX
//  id_ex_flush   out  1      insert bubble into ID/EX
//  ex_mem_stall  out  1      freeze EX/MEM
//  mem_timeout   out  1      sticky watchdog error
//  stall_cnt     out  CNT_W  cycles with pc_stall=1 (saturating)
//  flush_cnt     out  CNT_W  cycles with if_id_flush=1 (saturating)
// BEHAVIOUR
//  - Reset (rst=0): state RUN, flush/wait counters 0, mem_timeout=0, stall_cnt=flush_cnt=0. All stall and
//    flush outputs are forced to 0 while rst=0.
//  - FSM states: RUN, FLUSH, MEM_WAIT. Stall/flush outputs are combinational from state and inputs
//    (0-cycle latency). The counters are registered.
//  - load_use = ex_mem_read & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
//  - Priority, highest first: mem_busy > branch/FLUSH > load_use.
//  - mem_busy=1, any state: pc_stall, if_id_stall, id_ex_stall and ex_mem_stall are 1; both flushes 0.
//    Go to MEM_WAIT. The state being left (RUN or FLUSH) and its remaining flush count are preserved.
//  - MEM_WAIT: the wait counter increments each cycle, saturating at 255. When the count reaches
//    MEM_TIMEOUT, set mem_timeout (sticky until reset). When mem_busy=0, return to the preserved state in
//    the same cycle; the wait counter clears.
//  - RUN, branch_taken=1: if_id_flush=1 and id_ex_flush=1; pc_stall=0. load_use is ignored.
//    If FLUSH_CYCLES>1, go to FLUSH with remaining = FLUSH_CYCLES-1.
//  - FLUSH: if_id_flush=1, id_ex_flush=1, no stalls. remaining decrements each cycle; return to RUN after
//    the cycle in which it reaches 0. A new branch_taken in FLUSH reloads remaining = FLUSH_CYCLES-1.
//  - RUN, load_use=1, no branch: pc_stall=1, if_id_stall=1, id_ex_flush=1 for exactly that cycle. The
//    condition clears once the load advances. No state change.
//  - Counters: stall_cnt += 1 on every cycle with pc_stall=1. flush_cnt += 1 on every cycle with
//    if_id_flush=1. Both saturate at all-ones. cnt_clr has priority and zeroes both.
//  - Reset asserted mid-FLUSH or mid-MEM_WAIT: immediate return to RUN with all outputs 0.
// TESTING
//  - load x1 in EX (ex_mem_read=1, ex_rd=1); ID reads rs2=1 ->
//    1 cycle of pc_stall=if_id_stall=id_ex_flush=1; stall_cnt 0->1.
//  - ex_rd=0 with a matching rs1 read -> no stall (R0 excluded).
//  - branch_taken pulse, FLUSH_CYCLES=3 -> if_id_flush=id_ex_flush=1 for exactly 3 cycles;
//    flush_cnt=3; pc_stall=0.
//  - branch_taken and load_use in the same cycle -> flushes only, pc_stall=0.
//  - mem_busy for 4 cycles in the 2nd FLUSH cycle -> 4 all-stall cycles, then 2 more flush cycles.
//  - mem_busy held 256 cycles, MEM_TIMEOUT=255 -> mem_timeout=1 on cycle 255 and stays 1 after mem_busy=0;
//    stall_cnt=256.
//  - rst=0 pulse during MEM_WAIT -> outputs 0 immediately, counters 0; cnt_clr at 0xFFFF -> 0 next cycle.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage 16-bit pipeline.
// Resolves load-use, taken-branch, memory-wait and memory-timeout hazards and keeps perf counters.
module pipe_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT  = 255,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       id_rs1,
    input  logic [2:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_mem_read,
    input  logic [2:0]       ex_rd,
    input  logic             branch_taken,
    input  logic             mem_busy,
    input  logic             cnt_clr,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned REM_W  = 3;
    localparam int unsigned WAIT_W = 8;

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] FLUSH    = 2'd1;
    localparam logic [1:0] MEM_WAIT = 2'd2;

    localparam logic [REM_W-1:0]  REM_LOAD   = REM_W'(FLUSH_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX   = '1;
    localparam logic [WAIT_W-1:0] TIMEOUT_AT = WAIT_W'(MEM_TIMEOUT);

    logic [1:0]        state, state_nxt;
    logic [1:0]        ret_state, ret_state_nxt;
    logic [1:0]        eff_state;
    logic [REM_W-1:0]  rem, rem_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic              timeout_nxt;
    logic              load_use;

    logic pc_stall_c, if_id_stall_c, if_id_flush_c;
    logic id_ex_stall_c, id_ex_flush_c, ex_mem_stall_c;

    assign load_use = ex_mem_read && (ex_rd != 3'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

    // Leaving MEM_WAIT resumes the preserved state within the same cycle.
    assign eff_state = (state == MEM_WAIT) ? ret_state : state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            ret_state   <= RUN;
            rem         <= '0;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            ret_state   <= ret_state_nxt;
            rem         <= rem_nxt;
            wait_cnt    <= wait_cnt_nxt;
            mem_timeout <= timeout_nxt;
        end
    end

    // Next state and hazard controls; mem_busy > branch/FLUSH > load_use.
    always_comb begin
        state_nxt      = state;
        ret_state_nxt  = ret_state;
        rem_nxt        = rem;
        wait_cnt_nxt   = wait_cnt;
        timeout_nxt    = mem_timeout;
        pc_stall_c     = 1'b0;
        if_id_stall_c  = 1'b0;
        if_id_flush_c  = 1'b0;
        id_ex_stall_c  = 1'b0;
        id_ex_flush_c  = 1'b0;
        ex_mem_stall_c = 1'b0;

        if (mem_busy) begin
            pc_stall_c     = 1'b1;
            if_id_stall_c  = 1'b1;
            id_ex_stall_c  = 1'b1;
            ex_mem_stall_c = 1'b1;
            state_nxt      = MEM_WAIT;
            if (state != MEM_WAIT) begin
                ret_state_nxt = state;
            end
            if (wait_cnt != WAIT_MAX) begin
                wait_cnt_nxt = wait_cnt + WAIT_W'(1);
            end
            if (wait_cnt_nxt == TIMEOUT_AT) begin
                timeout_nxt = 1'b1;
            end
        end else begin
            wait_cnt_nxt = '0;
            if (eff_state == FLUSH) begin
                if_id_flush_c = 1'b1;
                id_ex_flush_c = 1'b1;
                if (branch_taken) begin
                    rem_nxt   = REM_LOAD;
                    state_nxt = FLUSH;
                end else if (rem <= REM_W'(1)) begin
                    rem_nxt   = '0;
                    state_nxt = RUN;
                end else begin
                    rem_nxt   = rem - REM_W'(1);
                    state_nxt = FLUSH;
                end
            end else begin
                state_nxt = RUN;
                if (branch_taken) begin
                    if_id_flush_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        rem_nxt   = REM_LOAD;
                        state_nxt = FLUSH;
                    end
                end else if (load_use) begin
                    pc_stall_c    = 1'b1;
                    if_id_stall_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                end
            end
        end
    end

    assign pc_stall     = rst & pc_stall_c;
    assign if_id_stall  = rst & if_id_stall_c;
    assign if_id_flush  = rst & if_id_flush_c;
    assign id_ex_stall  = rst & id_ex_stall_c;
    assign id_ex_flush  = rst & id_ex_flush_c;
    assign ex_mem_stall = rst & ex_mem_stall_c;

    // Saturating performance counters; cnt_clr wins over counting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (pc_stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (if_id_flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule
